// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared constants and state types for the console receiver
package console_pkg;

    // Register map (single address bit)
    localparam logic ADR_RXDATA = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    // STATUS bit positions; count occupies [9:4]
    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 4;

    // RXDATA valid flag sits just above the byte
    localparam int RXDATA_VALID = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_FETCH,
        WB_ACK
    } wb_state_e;

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - synchronous FIFO with registered read data
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   wr, din      push request and data (ignored when full)
//   rd, dout     pop request; dout is loaded with the popped entry on the next edge
//   empty, full  occupancy flags
//   count        number of stored entries (0..MEMORY_DEPTH)
module fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int MEMORY_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          rd,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(MEMORY_DEPTH):0] count
);

    localparam int AW = $clog2(MEMORY_DEPTH);
    localparam logic [AW:0] DEPTH_C = MEMORY_DEPTH[AW:0];

    logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign count = count_q;
    assign dout  = dout_q;

    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem_q[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/console_rx.sv
// rtl/console_rx.sv - Wishbone-readable 8N1 UART receiver with a receive FIFO
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   wb_cyc, wb_stb, wb_we  Wishbone cycle, strobe, write enable
//   wb_adr                 0 = RXDATA, 1 = STATUS
//   wb_dat_m2s, wb_dat_s2m write / read data
//   wb_ack                 one-cycle acknowledge
//   rx                     asynchronous serial input, idle high
//   irq                    high while the FIFO holds data
module console_rx
    import console_pkg::*;
#(
    parameter int FREQUENCY    = 25000000,
    parameter int BAUD_RATE    = 115200,
    parameter int DELAY_CLOCKS = FREQUENCY / BAUD_RATE,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic        wb_adr,
    input  logic [31:0] wb_dat_m2s,
    output logic [31:0] wb_dat_s2m,
    output logic        wb_ack,
    input  logic        rx,
    output logic        irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] DIV_LAST  = 32'(DELAY_CLOCKS - 1);
    localparam logic [31:0] HALF_LAST = 32'(DELAY_CLOCKS / 2 - 1);

    // Synchronizer and edge history
    logic rx_meta_q, rx_s_q, rx_prev_q;

    // Receiver
    rx_state_e   rx_state_q, rx_state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        push;
    logic        frm_set;
    logic        ovr_set;

    // FIFO
    logic             fifo_wr;
    logic             fifo_rd;
    logic [7:0]       fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    // Bus slave
    wb_state_e   wb_state_q, wb_state_d;
    logic        adr_q, adr_d;
    logic        we_q, we_d;
    logic        valid_q, valid_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic        ovr_clr;
    logic        frm_clr;
    logic [31:0] status_w;

    // Only the two sticky-clear bits of write data matter
    logic unused_wdata;
    assign unused_wdata = ^{wb_dat_m2s[31:4], wb_dat_m2s[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            shreg_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            shreg_q    <= shreg_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        shreg_d    = shreg_q;
        push       = 1'b0;
        frm_set    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                // Only a genuine 1->0 transition starts a frame, so a line
                // stuck low after a bad stop bit is never taken as a start.
                if (rx_prev_q && !rx_s_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (!rx_s_q) begin
                        rx_state_d = RX_DATA;
                        cnt_d      = '0;
                        n_d        = '0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    shreg_d[n_q] = rx_s_q;
                    cnt_d        = '0;
                    if (n_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        n_d = n_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == DIV_LAST) begin
                    if (rx_s_q) begin
                        push = 1'b1;
                    end else begin
                        frm_set = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign fifo_wr = push & ~fifo_full;
    assign ovr_set = push & fifo_full;

    fifo #(
        .DATA_WIDTH  (8),
        .MEMORY_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .wr   (fifo_wr),
        .din  (shreg_q),
        .rd   (fifo_rd),
        .dout (fifo_dout),
        .empty(fifo_empty),
        .full (fifo_full),
        .count(fifo_count)
    );

    always_comb begin
        status_w                   = '0;
        status_w[ST_NOT_EMPTY]     = ~fifo_empty;
        status_w[ST_FULL]          = fifo_full;
        status_w[ST_OVERRUN]       = overrun_q;
        status_w[ST_FRAME_ERR]     = frame_err_q;
        status_w[ST_COUNT_LSB +: 6] = 6'(fifo_count);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_state_q  <= WB_IDLE;
            adr_q       <= 1'b0;
            we_q        <= 1'b0;
            valid_q     <= 1'b0;
            wb_dat_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wb_state_q  <= wb_state_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            valid_q     <= valid_d;
            wb_dat_q    <= wb_dat_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        wb_state_d = wb_state_q;
        adr_d      = adr_q;
        we_d       = we_q;
        valid_d    = valid_q;
        wb_dat_d   = wb_dat_q;
        fifo_rd    = 1'b0;
        ovr_clr    = 1'b0;
        frm_clr    = 1'b0;
        case (wb_state_q)
            WB_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    adr_d   = wb_adr;
                    we_d    = wb_we;
                    // Pop now so the registered FIFO output is ready in FETCH
                    valid_d = ~wb_we & (wb_adr == ADR_RXDATA) & ~fifo_empty;
                    fifo_rd = valid_d;
                    if (wb_we && wb_adr == ADR_STATUS) begin
                        ovr_clr = wb_dat_m2s[ST_OVERRUN];
                        frm_clr = wb_dat_m2s[ST_FRAME_ERR];
                    end
                    wb_state_d = WB_FETCH;
                end
            end
            WB_FETCH: begin
                if (!we_q) begin
                    if (adr_q == ADR_STATUS) begin
                        wb_dat_d = status_w;
                    end else if (valid_q) begin
                        wb_dat_d = '0;
                        wb_dat_d[RXDATA_VALID] = 1'b1;
                        wb_dat_d[7:0]          = fifo_dout;
                    end else begin
                        wb_dat_d = '0;
                    end
                end
                wb_state_d = WB_ACK;
            end
            WB_ACK:  wb_state_d = WB_IDLE;
            default: wb_state_d = WB_IDLE;
        endcase
    end

    // Setting wins over a simultaneous clear so no event is lost
    assign overrun_d   = (overrun_q & ~ovr_clr) | ovr_set;
    assign frame_err_d = (frame_err_q & ~frm_clr) | frm_set;

    assign wb_ack     = (wb_state_q == WB_ACK) & wb_cyc & wb_stb;
    assign wb_dat_s2m = wb_dat_q;
    assign irq        = ~fifo_empty;

endmodule

// File: tb/tb_console_rx.sv
// tb/tb_console_rx.sv - scoreboard bench for console_rx with a queue-based reference model
module tb_console_rx;

    localparam int DIV   = 16;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic        wb_adr = 1'b0;
    logic [31:0] wb_dat_m2s = '0;
    logic [31:0] wb_dat_s2m;
    logic        wb_ack;
    logic        rx = 1'b1;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_write;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];
    bit         m_overrun = 1'b0;
    bit         m_frame = 1'b0;

    console_rx #(
        .FREQUENCY (1600000),
        .BAUD_RATE (100000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_dat_m2s(wb_dat_m2s),
        .wb_dat_s2m(wb_dat_s2m),
        .wb_ack    (wb_ack),
        .rx        (rx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0]   = (model_q.size() != 0);
        s[1]   = (model_q.size() == DEPTH);
        s[2]   = m_overrun;
        s[3]   = m_frame;
        s[9:4] = 6'(model_q.size());
        return s;
    endfunction

    // Monitor: every acknowledge consumes one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (wb_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (!e.is_write) begin
                    check("rd_data", wb_dat_s2m, e.data);
                end
            end
        end
    end

    task automatic wb_access(input bit we, input bit adr, input logic [31:0] dat);
        exp_t e;
        int   lat;
        @(posedge clk); #1;
        e.is_write = we;
        e.data     = '0;
        if (!we) begin
            if (adr == 1'b0) begin
                if (model_q.size() > 0) begin
                    e.data = {23'b0, 1'b1, model_q.pop_front()};
                end
            end else begin
                e.data = model_status();
            end
        end else if (adr == 1'b1) begin
            if (dat[2]) m_overrun = 1'b0;
            if (dat[3]) m_frame = 1'b0;
        end
        exp_q.push_back(e);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_m2s = dat;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (wb_ack !== 1'b1 && lat < 20);
        check("ack_latency", lat, 2);
        @(posedge clk); #1;
        check("ack_width", wb_ack, 1'b0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_dat_m2s = '0;
    endtask

    task automatic rd_data();
        wb_access(1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd_status();
        wb_access(1'b0, 1'b1, 32'h0);
    endtask

    task automatic wr_status(input logic [31:0] d);
        wb_access(1'b1, 1'b1, d);
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        @(posedge clk); #1;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop_ok);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (stop_ok) begin
            if (model_q.size() == DEPTH) m_overrun = 1'b1;
            else model_q.push_back(b);
        end else begin
            m_frame = 1'b1;
        end
        check("irq", irq, model_q.size() != 0);
    endtask

    task automatic glitch(input int n);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        logic [31:0] w;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", wb_ack, 1'b0);
        check("reset_dat", wb_dat_s2m, 32'h0);
        check("reset_irq", irq, 1'b0);
        rst = 1'b1;
        rd_status();

        // Single byte
        send_frame(8'h55, 1'b1);
        rd_status();
        rd_data();
        rd_status();
        check("irq_after_read", irq, 1'b0);

        // Short low pulse is not a start bit
        glitch(5);
        rd_status();

        // Framing error and its clear
        send_frame(8'hA5, 1'b0);
        rd_status();
        wr_status(32'h8);
        rd_status();

        // Fill past capacity
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1);
        rd_status();
        for (int i = 0; i < DEPTH; i++) rd_data();
        rd_data();
        rd_status();
        wr_status(32'h4);
        rd_status();

        // Empty read
        rd_data();
        rd_status();

        // Reset in the middle of a frame
        send_frame(8'h77, 1'b1);
        rd_status();
        @(posedge clk); #1;
        hold_bit(1'b0);
        for (int i = 0; i < 3; i++) hold_bit(1'b1);
        repeat (DIV / 2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midreset_ack", wb_ack, 1'b0);
        check("midreset_dat", wb_dat_s2m, 32'h0);
        check("midreset_irq", irq, 1'b0);
        model_q.delete();
        m_overrun = 1'b0;
        m_frame = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (DIV * 12) @(posedge clk);
        #1;
        rd_status();
        send_frame(8'h3C, 1'b1);
        rd_data();

        // Randomized mix
        for (int it = 0; it < 70; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                w = $urandom;
                send_frame(w[7:0], $urandom_range(0, 7) != 0);
            end else if (r == 5) begin
                glitch($urandom_range(1, 5));
            end else if (r <= 7) begin
                rd_data();
            end else if (r == 8) begin
                rd_status();
            end else begin
                w = $urandom;
                wr_status(w);
            end
        end
        rd_status();

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
